// File: rtl/morse_pkg.sv
// Shared Morse symbol codes, sequencer state encoding and the A..H letter table.
// The downstream dash/dot display stage decodes the same symbol codes.
package morse_pkg;

  localparam logic [1:0] MorseLGap = 2'h0;
  localparam logic [1:0] MorseDot  = 2'h1;
  localparam logic [1:0] MorseDash = 2'h2;

  typedef enum logic [1:0] {
    StIdle,
    StSymbol,
    StSgap,
    StLgap
  } state_e;

  // Returns {length[2:0], pattern[3:0]}; pattern is MSB-first, 1 = dash.
  function automatic logic [6:0] letter_code(input logic [2:0] letter);
    logic [6:0] code;
    case (letter)
      3'd0:    code = {3'd2, 4'b0100};
      3'd1:    code = {3'd4, 4'b1000};
      3'd2:    code = {3'd4, 4'b1010};
      3'd3:    code = {3'd3, 4'b1000};
      3'd4:    code = {3'd1, 4'b0000};
      3'd5:    code = {3'd4, 4'b0010};
      3'd6:    code = {3'd3, 4'b1100};
      default: code = {3'd4, 4'b0000};
    endcase
    return code;
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Tick and unit down-counters; Expire pulses on the last cycle of a loaded duration.
// Units carries the duration in Morse units minus one (0 = 1 unit, 2 = 3 units).
module morse_unit_timer #(
  parameter int unsigned TICKS = 25_000_000
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Load,
  input  logic [1:0] Units,
  output logic       Expire
);

  localparam int unsigned CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [CNT_W-1:0] TickMax = CNT_W'(TICKS - 1);

  logic [CNT_W-1:0] tick_q;
  logic [1:0]       unit_q;
  logic             run_q;

  assign Expire = run_q && (tick_q == '0) && (unit_q == 2'd0);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      tick_q <= '0;
      unit_q <= 2'd0;
      run_q  <= 1'b0;
    end else if (Load) begin
      tick_q <= TickMax;
      unit_q <= Units;
      run_q  <= 1'b1;
    end else if (run_q) begin
      if (tick_q == '0) begin
        tick_q <= TickMax;
        if (unit_q == 2'd0) begin
          run_q <= 1'b0;
        end else begin
          unit_q <= unit_q - 2'd1;
        end
      end else begin
        tick_q <= tick_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/morse_letter_sequencer.sv
// Plays one Morse letter (A..H) per accepted Start as timed Dot/Dash/LGap symbols.
// All outputs are registered; the first symbol appears one cycle after Start is sampled.
module morse_letter_sequencer
  import morse_pkg::*;
#(
  parameter int unsigned TICKS = 25_000_000
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Start,
  input  logic [2:0] Letter,
  output logic [1:0] Morse,
  output logic       Busy,
  output logic       Done
);

  state_e     state_q, state_d;
  logic [2:0] len_q, len_d;
  logic [3:0] pat_q, pat_d;
  logic [1:0] idx_q, idx_d;
  logic [1:0] morse_d;
  logic       busy_d, done_d;
  logic       load;
  logic [1:0] units;
  logic       expire;
  logic [6:0] code;

  assign code = letter_code(Letter);

  morse_unit_timer #(
    .TICKS (TICKS)
  ) u_timer (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Load   (load),
    .Units  (units),
    .Expire (expire)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= StIdle;
      len_q   <= 3'd0;
      pat_q   <= 4'd0;
      idx_q   <= 2'd0;
      Morse   <= MorseLGap;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      Morse   <= morse_d;
      Busy    <= busy_d;
      Done    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    load    = 1'b0;
    units   = 2'd0;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          len_d   = code[6:4];
          pat_d   = code[3:0];
          idx_d   = 2'd0;
          load    = 1'b1;
          units   = code[3] ? 2'd2 : 2'd0;
          state_d = StSymbol;
        end
      end
      StSymbol: begin
        if (expire) begin
          load = 1'b1;
          if (({1'b0, idx_q} + 3'd1) < len_q) begin
            units   = 2'd0;
            state_d = StSgap;
          end else begin
            units   = 2'd2;
            state_d = StLgap;
          end
        end
      end
      StSgap: begin
        if (expire) begin
          idx_d   = idx_q + 2'd1;
          load    = 1'b1;
          units   = pat_q[2'd3 - idx_d] ? 2'd2 : 2'd0;
          state_d = StSymbol;
        end
      end
      StLgap: begin
        if (expire) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are derived from the next state so the registered copies line up with it.
  always_comb begin
    morse_d = MorseLGap;
    if (state_d == StSymbol) begin
      morse_d = pat_d[2'd3 - idx_d] ? MorseDash : MorseDot;
    end
    busy_d = (state_d != StIdle);
    done_d = (state_q == StLgap) && (state_d == StIdle);
  end

endmodule

// File: tb/tb_morse_letter_sequencer.sv
// Self-checking bench: a dot/dash string model predicts every cycle's outputs,
// and directed scenarios pin hand-counted cycle positions.
module tb_morse_letter_sequencer;

  localparam int T = 4;

  logic       Clock;
  logic       Resetn;
  logic       Start;
  logic [2:0] Letter;
  logic [1:0] Morse;
  logic       Busy;
  logic       Done;

  int  checks = 0;
  int  errors = 0;
  int  accepts = 0;
  bit  clk_en = 0;
  bit  compare_en = 0;

  morse_letter_sequencer #(
    .TICKS (T)
  ) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Start  (Start),
    .Letter (Letter),
    .Morse  (Morse),
    .Busy   (Busy),
    .Done   (Done)
  );

  initial begin
    Clock = 0;
    wait (clk_en);
    forever #5 Clock = ~Clock;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each expected entry is {morse[1:0], busy, done} for one cycle.
  string codes [8] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "...."};
  logic [3:0] exp_q[$];
  logic [3:0] cur = 4'b0;

  task automatic push_letter(input int l);
    string s;
    int u;
    logic [1:0] sym;
    s = codes[l];
    for (int i = 0; i < s.len(); i++) begin
      u   = (s[i] == "-") ? 3 : 1;
      sym = (s[i] == "-") ? 2'd2 : 2'd1;
      repeat (u * T) exp_q.push_back({sym, 1'b1, 1'b0});
      if (i != s.len() - 1) repeat (T) exp_q.push_back(4'b0010);
    end
    repeat (3 * T) exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001);
  endtask

  always @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      exp_q.delete();
      cur = 4'b0;
    end else begin
      if (!cur[1] && Start) begin
        push_letter(int'(Letter));
        accepts++;
      end
      cur = (exp_q.size() != 0) ? exp_q.pop_front() : 4'b0;
    end
  end

  always @(negedge Clock) begin
    if (compare_en) begin
      check("morse", Morse, cur[3:2]);
      check("busy", Busy, cur[1]);
      check("done", Done, cur[0]);
      check("morse_legal", (Morse == 2'h3), 0);
    end
  end

  // Start sampled at the next posedge (edge 0); returns at the negedge of cycle 1.
  task automatic play(input logic [2:0] l);
    @(negedge Clock);
    Start  = 1;
    Letter = l;
    @(posedge Clock);
    @(negedge Clock);
    Start = 0;
  endtask

  int cyc;
  int done_seen;
  int base;

  initial begin
    Start  = 0;
    Letter = 0;
    Resetn = 1;
    #2 Resetn = 0;
    #1;
    check("reset_morse", Morse, 0);
    check("reset_busy", Busy, 0);
    check("reset_done", Done, 0);
    clk_en = 1;
    repeat (2) @(negedge Clock);
    Resetn = 1;
    compare_en = 1;
    repeat (3) @(negedge Clock);

    // E: single dot
    play(3'd4);
    check("E_c1_morse", Morse, 1);
    repeat (3) @(negedge Clock);
    check("E_c4_morse", Morse, 1);
    @(negedge Clock);
    check("E_c5_morse", Morse, 0);
    check("E_c5_busy", Busy, 1);
    repeat (11) @(negedge Clock);
    check("E_c16_busy", Busy, 1);
    @(negedge Clock);
    check("E_c17_done", Done, 1);
    check("E_c17_busy", Busy, 0);
    @(negedge Clock);
    check("E_c18_done", Done, 0);
    repeat (4) @(negedge Clock);

    // B with Letter change and a Start pulse while busy, both ignored
    play(3'd1);
    for (cyc = 1; cyc <= 50; cyc++) begin
      if (cyc == 3) Letter = 3'd4;
      if (cyc == 6) Start = 1;
      if (cyc == 7) Start = 0;
      if (cyc == 12) check("B_c12_morse", Morse, 2);
      if (cyc == 13) check("B_c13_morse", Morse, 0);
      if (cyc == 17) check("B_c17_morse", Morse, 1);
      if (cyc == 48) check("B_c48_busy", Busy, 1);
      if (cyc == 49) check("B_c49_done", Done, 1);
      if (cyc == 50) check("B_c50_done", Done, 0);
      @(negedge Clock);
    end

    // G with reset dropped mid-dash
    play(3'd6);
    repeat (6) @(negedge Clock);
    check("G_c7_morse", Morse, 2);
    #2 Resetn = 0;
    #1;
    check("G_rst_morse", Morse, 0);
    check("G_rst_busy", Busy, 0);
    repeat (2) @(negedge Clock);
    Resetn = 1;
    done_seen = 0;
    repeat (30) begin
      @(negedge Clock);
      if (Done) done_seen++;
    end
    check("G_no_done", done_seen, 0);
    check("G_idle_busy", Busy, 0);

    // A then D back-to-back
    play(3'd0);
    cyc = 1;
    while (!Done && cyc < 100) begin
      @(negedge Clock);
      cyc++;
    end
    check("A_done_cycle", cyc, 33);
    Start  = 1;
    Letter = 3'd3;
    @(posedge Clock);
    @(negedge Clock);
    Start = 0;
    check("D_first_morse", Morse, 2);
    check("D_first_busy", Busy, 1);
    repeat (50) @(negedge Clock);

    // Randomized run of 200 letters
    base = accepts;
    cyc  = 0;
    while (accepts < base + 200 && cyc < 20000) begin
      @(negedge Clock);
      Start  = ($urandom_range(0, 3) != 0);
      Letter = 3'($urandom_range(0, 7));
      cyc++;
    end
    Start = 0;
    check("random_letters_played", accepts - base, 200);
    repeat (60) @(negedge Clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
